mem_req_arbiter: RTL and testbench

- Parametrised N-requestor arbiter that merges per-requestor ready/valid request channels onto a single memory request port.
- Successor to the fixed 4-way priority-mux-with-registered-valid block.
- Adds selectable fixed-priority or round-robin arbitration, multi-beat packet locking, a data path with requestor ID, and a registered output stage with full ready/valid backpressure.
- Sits between client ports and the memory interface.

---
 rtl/mem_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// N-way request arbiter onto a single registered memory request port.
// Fixed-priority or round-robin selection, with multi-beat packet locking.
module mem_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  output logic [NUM_REQ-1:0]        io_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_bits,
  input  logic [NUM_REQ-1:0]        io_req_last,
  output logic                      io_mem_valid,
  input  logic                      io_mem_ready,
  output logic [DATA_W-1:0]         io_mem_bits,
  output logic                      io_mem_last,
  output logic [ID_W-1:0]           io_mem_id,
  output logic                      io_busy
);

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // valid never waits on ready, and ready is only raised to a valid requestor.

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     lock_idx_q, lock_idx_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0]   mem_bits_q, mem_bits_d;
  logic                mem_last_q, mem_last_d;
  logic [ID_W-1:0]     mem_id_q, mem_id_d;

  logic [ID_W-1:0]     grant_idx;
  logic                grant_vld;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [DATA_W-1:0]   sel_bits;
  logic                sel_last;
  logic                can_accept;
  logic                xfer;

  // Grant selection; in round-robin the scan runs from the farthest slot
  // inward so the nearest valid slot after ptr_q is the last to overwrite.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_idx = lock_idx_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ID_W'(i) == lock_idx_q) begin
          grant_vld = io_req_valid[i];
        end
      end
    end else if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (io_req_valid[i]) begin
          grant_idx = ID_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (io_req_valid[idx]) begin
          grant_idx = ID_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    sel_bits     = '0;
    sel_last     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (ID_W'(i) == grant_idx)) begin
        grant_onehot[i] = 1'b1;
        sel_bits        = io_req_bits[i*DATA_W +: DATA_W];
        sel_last        = io_req_last[i];
      end
    end
  end

  assign can_accept   = !mem_valid_q || io_mem_ready;
  assign xfer         = grant_vld && can_accept;
  assign io_req_ready = can_accept ? grant_onehot : '0;

  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    ptr_d       = ptr_q;
    mem_valid_d = mem_valid_q;
    mem_bits_d  = mem_bits_q;
    mem_last_d  = mem_last_q;
    mem_id_d    = mem_id_q;
    if (xfer) begin
      mem_valid_d = 1'b1;
      mem_bits_d  = sel_bits;
      mem_last_d  = sel_last;
      mem_id_d    = grant_idx;
      if (state_q == ST_UNLOCKED && !sel_last) begin
        state_d    = ST_LOCKED;
        lock_idx_d = grant_idx;
      end else if (state_q == ST_LOCKED && sel_last) begin
        state_d = ST_UNLOCKED;
      end
      // Pointer advances only when a packet completes.
      if (RR_MODE != 0 && sel_last) begin
        ptr_d = grant_idx;
      end
    end else if (io_mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      lock_idx_q  <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      mem_valid_q <= 1'b0;
      mem_bits_q  <= '0;
      mem_last_q  <= 1'b0;
      mem_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      ptr_q       <= ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_bits_q  <= mem_bits_d;
      mem_last_q  <= mem_last_d;
      mem_id_q    <= mem_id_d;
    end
  end

  assign io_mem_valid = mem_valid_q;
  assign io_mem_bits  = mem_bits_q;
  assign io_mem_last  = mem_last_q;
  assign io_mem_id    = mem_id_q;
  assign io_busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: round-robin, fixed-priority and
// 3-requestor instances driven from one linear sequence of steps.
module tb_mem_req_arbiter;

  logic clk;
  logic reset;

  // Instance a: NUM_REQ=4, round-robin
  logic [3:0]   a_valid, a_ready, a_last;
  logic [127:0] a_bits;
  logic         a_mem_valid, a_mem_ready, a_mem_last, a_busy;
  logic [31:0]  a_mem_bits;
  logic [1:0]   a_mem_id;

  // Instance b: NUM_REQ=4, fixed priority
  logic [3:0]   b_valid, b_ready, b_last;
  logic [127:0] b_bits;
  logic         b_mem_valid, b_mem_ready, b_mem_last, b_busy;
  logic [31:0]  b_mem_bits;
  logic [1:0]   b_mem_id;

  // Instance c: NUM_REQ=3, round-robin
  logic [2:0]   c_valid, c_ready, c_last;
  logic [95:0]  c_bits;
  logic         c_mem_valid, c_mem_ready, c_mem_last, c_busy;
  logic [31:0]  c_mem_bits;
  logic [1:0]   c_mem_id;

  int n_checks;
  int n_fail;

  mem_req_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2), .RR_MODE(1)) dut_a (
    .clk(clk), .reset(reset),
    .io_req_valid(a_valid), .io_req_ready(a_ready), .io_req_bits(a_bits),
    .io_req_last(a_last), .io_mem_valid(a_mem_valid), .io_mem_ready(a_mem_ready),
    .io_mem_bits(a_mem_bits), .io_mem_last(a_mem_last), .io_mem_id(a_mem_id),
    .io_busy(a_busy)
  );

  mem_req_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2), .RR_MODE(0)) dut_b (
    .clk(clk), .reset(reset),
    .io_req_valid(b_valid), .io_req_ready(b_ready), .io_req_bits(b_bits),
    .io_req_last(b_last), .io_mem_valid(b_mem_valid), .io_mem_ready(b_mem_ready),
    .io_mem_bits(b_mem_bits), .io_mem_last(b_mem_last), .io_mem_id(b_mem_id),
    .io_busy(b_busy)
  );

  mem_req_arbiter #(.NUM_REQ(3), .DATA_W(32), .ID_W(2), .RR_MODE(1)) dut_c (
    .clk(clk), .reset(reset),
    .io_req_valid(c_valid), .io_req_ready(c_ready), .io_req_bits(c_bits),
    .io_req_last(c_last), .io_mem_valid(c_mem_valid), .io_mem_ready(c_mem_ready),
    .io_mem_bits(c_mem_bits), .io_mem_last(c_mem_last), .io_mem_id(c_mem_id),
    .io_busy(c_busy)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    a_valid     = '0; a_last = '0; a_bits = '0; a_mem_ready = 1'b1;
    b_valid     = '0; b_last = '0; b_bits = '0; b_mem_ready = 1'b1;
    c_valid     = '0; c_last = '0; c_bits = '0; c_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_bits[i*32 +: 32] = 32'h100 + 32'(i);
      b_bits[i*32 +: 32] = 32'h200 + 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      c_bits[i*32 +: 32] = 32'h300 + 32'(i);
    end
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mem_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_busy",      32'(a_busy),      32'd0);
    chk("rst_mem_bits",  a_mem_bits,       32'd0);
    chk("rst_mem_id",    32'(a_mem_id),    32'd0);
    chk("rst_mem_last",  32'(a_mem_last),  32'd0);

    // Round-robin, all valid, single-beat: grants 0,1,2,3,0 back to back
    a_valid = 4'hF;
    a_last  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_ready", 32'(a_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_mem_id",    32'(a_mem_id),    32'(k % 4));
      chk("rr_mem_valid", 32'(a_mem_valid), 32'd1);
      chk("rr_mem_bits",  a_mem_bits,       32'h100 + 32'(k % 4));
    end
    a_valid = '0;

    // Fixed priority: 3 beats 1 while valid, then 1 wins
    b_valid = 4'b1010;
    b_last  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("fp_ready_hi", 32'(b_ready), 32'(4'b1000));
      tick();
      chk("fp_mem_id_hi", 32'(b_mem_id), 32'd3);
    end
    b_valid = 4'b0010;
    settle();
    chk("fp_ready_lo", 32'(b_ready), 32'(4'b0010));
    tick();
    chk("fp_mem_id_lo",   32'(b_mem_id), 32'd1);
    chk("fp_mem_bits_lo", b_mem_bits,    32'h201);
    b_valid = '0;
    tick();
    chk("fp_idle_valid", 32'(b_mem_valid), 32'd0);

    // Move RR pointer to 1 with a single beat from requestor 1
    a_valid = 4'b0010;
    a_last  = 4'hF;
    settle();
    chk("pre_lock_ready", 32'(a_ready), 32'(4'b0010));
    tick();
    chk("pre_lock_id", 32'(a_mem_id), 32'd1);

    // Requestor 2 three-beat packet with 0 and 1 also valid
    a_valid = 4'b0111;
    a_last  = 4'b0011;
    settle();
    chk("lock_b1_ready", 32'(a_ready), 32'(4'b0100));
    tick();
    chk("lock_b1_busy", 32'(a_busy),   32'd1);
    chk("lock_b1_id",   32'(a_mem_id), 32'd2);
    chk("lock_b1_last", 32'(a_mem_last), 32'd0);
    a_valid = 4'b0011;
    settle();
    chk("lock_gap_ready", 32'(a_ready), 32'd0);
    tick();
    chk("lock_gap_busy",  32'(a_busy),      32'd1);
    chk("lock_gap_valid", 32'(a_mem_valid), 32'd0);
    a_valid = 4'b0111;
    settle();
    chk("lock_b2_ready", 32'(a_ready), 32'(4'b0100));
    tick();
    chk("lock_b2_busy", 32'(a_busy), 32'd1);
    a_last = 4'b0111;
    settle();
    chk("lock_b3_ready", 32'(a_ready), 32'(4'b0100));
    chk("lock_b3_busy_pre", 32'(a_busy), 32'd1);
    tick();
    chk("lock_b3_busy", 32'(a_busy),     32'd0);
    chk("lock_b3_id",   32'(a_mem_id),   32'd2);
    chk("lock_b3_last", 32'(a_mem_last), 32'd1);
    a_valid = 4'b1011;
    a_last  = 4'hF;
    settle();
    chk("post_lock_ready", 32'(a_ready), 32'(4'b1000));
    tick();
    chk("post_lock_id", 32'(a_mem_id), 32'd3);

    // Backpressure with DEADBEEF held
    a_valid = 4'b0001;
    a_bits[31:0] = 32'hDEADBEEF;
    settle();
    chk("bp_load_ready", 32'(a_ready), 32'(4'b0001));
    tick();
    chk("bp_load_bits", a_mem_bits, 32'hDEADBEEF);
    a_mem_ready  = 1'b0;
    a_bits[31:0] = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_ready", 32'(a_ready), 32'd0);
      tick();
      chk("bp_hold_bits",  a_mem_bits,       32'hDEADBEEF);
      chk("bp_hold_valid", 32'(a_mem_valid), 32'd1);
    end
    a_mem_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(a_ready), 32'(4'b0001));
    tick();
    chk("bp_next_bits",  a_mem_bits,       32'h12345678);
    chk("bp_next_valid", 32'(a_mem_valid), 32'd1);

    // Reset during a locked packet with a held beat
    a_valid = 4'b0010;
    a_last  = 4'b0000;
    tick();
    chk("mid_rst_busy_pre",  32'(a_busy),      32'd1);
    chk("mid_rst_valid_pre", 32'(a_mem_valid), 32'd1);
    a_mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(a_mem_valid), 32'd0);
    chk("mid_rst_busy",  32'(a_busy),      32'd0);
    chk("mid_rst_bits",  a_mem_bits,       32'd0);
    a_valid     = 4'hF;
    a_last      = 4'hF;
    a_mem_ready = 1'b1;
    settle();
    chk("mid_rst_ready", 32'(a_ready), 32'(4'b0001));
    tick();
    chk("mid_rst_id", 32'(a_mem_id), 32'd0);
    a_valid = '0;

    // Three requestors: pointer wraps 2 -> 0
    c_valid = 3'b111;
    c_last  = 3'b111;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("n3_ready", 32'(c_ready), 32'(3'b001 << (k % 3)));
      tick();
      chk("n3_mem_id",   32'(c_mem_id),   32'(k % 3));
      chk("n3_mem_bits", c_mem_bits,      32'h300 + 32'(k % 3));
    end
    c_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
